// File: rtl/seq_multiplier_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package seq_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_e;

    // Widest operand the magnitude helper handles.
    localparam int unsigned MaxOperandWidth = 64;
    localparam int unsigned MaxIdxWidth     = $clog2(MaxOperandWidth);

    function automatic int unsigned num_steps(input int unsigned width, input int unsigned step_bits);
        return width / step_bits;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned step_bits);
        return $clog2(width / step_bits + 1);
    endfunction

    // Unsigned magnitude of a width-bit operand; -2^(width-1) maps to 2^(width-1).
    function automatic logic [MaxOperandWidth-1:0] abs_mag(
        input logic [MaxOperandWidth-1:0] value,
        input int unsigned                width,
        input logic                       is_signed
    );
        logic [MaxOperandWidth-1:0] mask;
        logic [MaxOperandWidth-1:0] mag;
        mask = '1;
        mask = mask >> (MaxOperandWidth - width);
        mag  = value & mask;
        if (is_signed && value[MaxIdxWidth'(width - 1)]) begin
            mag = (~mag + MaxOperandWidth'(1)) & mask;
        end
        return mag;
    endfunction

endpackage

// File: rtl/seq_mult_pp_gen.sv
// Partial product of the multiplicand magnitude and one StepBits-wide multiplier group.
module seq_mult_pp_gen
    import seq_multiplier_pkg::*;
#(
    parameter int unsigned OperandWidth = 32,
    parameter int unsigned StepBits     = 1
) (
    input  logic [OperandWidth-1:0]          mag_a,
    input  logic [StepBits-1:0]              group,
    output logic [OperandWidth+StepBits-1:0] pp_c
);

    localparam int unsigned PpWidth = OperandWidth + StepBits;

    assign pp_c = PpWidth'(mag_a) * PpWidth'(group);

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier with valid/ready handshakes, StepBits multiplier bits per cycle.
// Optional SEQ_MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier magnitude is zero.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int unsigned OperandWidth = 32,
    parameter int unsigned StepBits     = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic                      signed_i,
    input  logic [OperandWidth-1:0]   operand_a_i,
    input  logic [OperandWidth-1:0]   operand_b_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [2*OperandWidth-1:0] result_o,
    output logic                      busy_o
);

    localparam int unsigned NumSteps = num_steps(OperandWidth, StepBits);
    localparam int unsigned CntWidth = cnt_width(OperandWidth, StepBits);
    localparam int unsigned AccWidth = 2 * OperandWidth;
    localparam int unsigned PpWidth  = OperandWidth + StepBits;

    if (StepBits == 0) begin : g_bad_zero_step
        $error("seq_multiplier: StepBits must be nonzero");
    end else if (OperandWidth % StepBits != 0) begin : g_bad_step
        $error("seq_multiplier: StepBits must divide OperandWidth");
    end
    if (OperandWidth > MaxOperandWidth) begin : g_bad_width
        $error("seq_multiplier: OperandWidth exceeds MaxOperandWidth");
    end

    mult_state_e             state_q;
    logic [AccWidth-1:0]     acc_q;
    logic [OperandWidth-1:0] mag_a_q;
    logic [OperandWidth-1:0] mag_b_q;
    logic [CntWidth-1:0]     step_q;
    logic                    neg_q;

    logic [PpWidth-1:0]      pp;
    logic [AccWidth-1:0]     pp_shifted;
    logic [OperandWidth-1:0] mag_a_in;
    logic [OperandWidth-1:0] mag_b_in;
    logic                    last_step;

    assign mag_a_in = OperandWidth'(abs_mag(MaxOperandWidth'(operand_a_i), OperandWidth, signed_i));
    assign mag_b_in = OperandWidth'(abs_mag(MaxOperandWidth'(operand_b_i), OperandWidth, signed_i));

    seq_mult_pp_gen #(
        .OperandWidth(OperandWidth),
        .StepBits    (StepBits)
    ) u_pp_gen (
        .mag_a(mag_a_q),
        .group(mag_b_q[StepBits-1:0]),
        .pp_c (pp)
    );

    assign pp_shifted = AccWidth'(pp) << (32'(step_q) * StepBits);

    // BUSY spends one extra cycle after the last group so latency is NumSteps+1.
`ifdef SEQ_MULT_EARLY_TERM_EN
    assign last_step = (step_q == CntWidth'(NumSteps)) ||
                       ((mag_b_q == '0) && (step_q != '0));
`else
    assign last_step = (step_q == CntWidth'(NumSteps));
`endif

    assign result_o = neg_q ? (~acc_q + AccWidth'(1)) : acc_q;

    // Control FSM, accumulator datapath and registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            step_q      <= '0;
            neg_q       <= 1'b0;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
        end else if (clear_i) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            step_q      <= '0;
            neg_q       <= 1'b0;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i && in_ready_o) begin
                        mag_a_q    <= mag_a_in;
                        mag_b_q    <= mag_b_in;
                        neg_q      <= signed_i & (operand_a_i[OperandWidth-1] ^ operand_b_i[OperandWidth-1]);
                        acc_q      <= '0;
                        step_q     <= '0;
                        state_q    <= BUSY;
                        in_ready_o <= 1'b0;
                        busy_o     <= 1'b1;
                    end
                end
                BUSY: begin
                    if (last_step) begin
                        state_q     <= DONE;
                        out_valid_o <= 1'b1;
                    end else begin
                        acc_q   <= acc_q + pp_shifted;
                        mag_b_q <= mag_b_q >> StepBits;
                        step_q  <= step_q + CntWidth'(1);
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q     <= IDLE;
                        out_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        in_ready_o  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_o  <= 1'b1;
                    out_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed-vector bench for seq_multiplier: an 8-bit/1-bit-step and a 32-bit/4-bit-step instance.
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid8, in_ready8, sgn8, out_valid8, out_ready8, busy8, clear8;
    logic [7:0]  a8, b8;
    logic [15:0] result8;

    logic        in_valid32, in_ready32, sgn32, out_valid32, out_ready32, busy32, clear32;
    logic [31:0] a32, b32;
    logic [63:0] result32;

    int vectors     = 0;
    int miscompares = 0;

    seq_multiplier #(.OperandWidth(8), .StepBits(1)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear8),
        .in_valid_i(in_valid8), .in_ready_o(in_ready8), .signed_i(sgn8),
        .operand_a_i(a8), .operand_b_i(b8),
        .out_valid_o(out_valid8), .out_ready_i(out_ready8),
        .result_o(result8), .busy_o(busy8)
    );

    seq_multiplier #(.OperandWidth(32), .StepBits(4)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear32),
        .in_valid_i(in_valid32), .in_ready_o(in_ready32), .signed_i(sgn32),
        .operand_a_i(a32), .operand_b_i(b32),
        .out_valid_o(out_valid32), .out_ready_i(out_ready32),
        .result_o(result32), .busy_o(busy32)
    );

    // Expected latency depends on whether the early-termination build is under test.
    function automatic int pick_lat(input int fixed_lat, input int early_lat);
`ifdef SEQ_MULT_EARLY_TERM_EN
        return early_lat;
`else
        return fixed_lat;
`endif
    endfunction

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic sgn);
        @(negedge clk);
        vectors++;
        if (in_ready8 !== 1'b1) begin
            miscompares++;
            $display("FAIL start8_in_ready: got %b want 1", in_ready8);
        end
        a8 = a; b8 = b; sgn8 = sgn; in_valid8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
    endtask

    // Runs one 8-bit op to DONE, checks latency and product; optionally completes the handshake.
    task automatic op8(input string name, input logic [7:0] a, input logic [7:0] b, input logic sgn,
                       input logic [15:0] exp, input int exp_lat, input bit drain);
        int lat;
        start8(a, b, sgn);
        lat = 0;
        while (out_valid8 !== 1'b1 && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        vectors++;
        if (lat != exp_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        vectors++;
        if (result8 !== exp) begin
            miscompares++;
            $display("FAIL %s result: got %h want %h", name, result8, exp);
        end
        if (drain) begin
            out_ready8 = 1'b1;
            @(posedge clk); @(negedge clk);
            out_ready8 = 1'b0;
            vectors++;
            if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || busy8 !== 1'b0) begin
                miscompares++;
                $display("FAIL %s drain: got v=%b r=%b b=%b want 0 1 0", name, out_valid8, in_ready8, busy8);
            end
        end
    endtask

    task automatic op32(input string name, input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [63:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        a32 = a; b32 = b; sgn32 = sgn; in_valid32 = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid32 = 1'b0;
        lat = 0;
        while (out_valid32 !== 1'b1 && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        vectors++;
        if (lat != exp_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        vectors++;
        if (result32 !== exp) begin
            miscompares++;
            $display("FAIL %s result: got %h want %h", name, result32, exp);
        end
        out_ready32 = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready32 = 1'b0;
        vectors++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin
            miscompares++;
            $display("FAIL %s drain: got v=%b r=%b want 0 1", name, out_valid32, in_ready32);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        vectors++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || busy8 !== 1'b0 || result8 !== 16'h0) begin
            miscompares++;
            $display("FAIL %s dut8: got r=%b v=%b b=%b res=%h want 1 0 0 0000",
                     name, in_ready8, out_valid8, busy8, result8);
        end
        vectors++;
        if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0 || busy32 !== 1'b0 || result32 !== 64'h0) begin
            miscompares++;
            $display("FAIL %s dut32: got r=%b v=%b b=%b res=%h want 1 0 0 0",
                     name, in_ready32, out_valid32, busy32, result32);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic8();
        op8("u3x5",      8'd3,   8'd5,   1'b0, 16'h000F, pick_lat(9, 4), 1'b1);
        op8("u255x255",  8'hFF,  8'hFF,  1'b0, 16'hFE01, pick_lat(9, 9), 1'b1);
        op8("sm128xm128", 8'h80, 8'h80,  1'b1, 16'h4000, pick_lat(9, 9), 1'b1);
        op8("sm3x5",     8'hFD,  8'h05,  1'b1, 16'hFFF1, pick_lat(9, 4), 1'b1);
        op8("s127xm1",   8'h7F,  8'hFF,  1'b1, 16'hFF81, pick_lat(9, 2), 1'b1);
    endtask

    // Hold out_ready low in DONE while offering new operands that must be ignored.
    task automatic test_backpressure();
        op8("bp9x9", 8'd9, 8'd9, 1'b0, 16'h0051, pick_lat(9, 5), 1'b0);
        a8 = 8'd1; b8 = 8'd1; in_valid8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            vectors++;
            if (out_valid8 !== 1'b1 || result8 !== 16'h0051 || in_ready8 !== 1'b0 || busy8 !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d: got v=%b res=%h r=%b b=%b want 1 0051 0 1",
                         i, out_valid8, result8, in_ready8, busy8);
            end
        end
        out_ready8 = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready8 = 1'b0;
        in_valid8  = 1'b0;
        vectors++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || busy8 !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: got v=%b r=%b b=%b want 0 1 0", out_valid8, in_ready8, busy8);
        end
    endtask

    task automatic test_clear();
        bit seen;
        start8(8'd100, 8'd100, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear8 = 1'b1;
        @(posedge clk); @(negedge clk);
        clear8 = 1'b0;
        vectors++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || busy8 !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_idle: got v=%b r=%b b=%b want 0 1 0", out_valid8, in_ready8, busy8);
        end
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid8 === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_no_valid: got out_valid seen=%b want 0", seen);
        end
        op8("u7x6", 8'd7, 8'd6, 1'b0, 16'h002A, pick_lat(9, 4), 1'b1);
    endtask

    task automatic test_reset_mid();
        start8(8'd200, 8'd200, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        op8("u2x2", 8'd2, 8'd2, 1'b0, 16'h0004, pick_lat(9, 3), 1'b1);
    endtask

    task automatic test_wide32();
        op32("w_umax",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, pick_lat(9, 9));
        op32("w_sm1m1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, pick_lat(9, 2));
        op32("w_smin2",  32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, pick_lat(9, 9));
        op32("w_b10",    32'h1234_5678, 32'h0000_0010, 1'b1, 64'h0000_0001_2345_6780, pick_lat(9, 3));
        op32("w_sm2x3",  32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, pick_lat(9, 2));
        op32("w_u2x3",   32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 64'h0000_0002_FFFF_FFFA, pick_lat(9, 2));
        op32("w_u16x16", 32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000, pick_lat(9, 6));
    endtask

    initial begin
        in_valid8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b0; clear8 = 1'b0;
        in_valid32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0; out_ready32 = 1'b0; clear32 = 1'b0;
        test_reset();
        test_basic8();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_wide32();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
